// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and receiver state encoding for the buffered UART receiver
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - receive FIFO with occupancy count; a push into a full FIFO is dropped unless a pop frees the slot
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && valid;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 16x oversampled 8N1 UART receiver feeding a ready/valid FIFO with sticky error flags
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 13,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  output logic [7:0]                    data,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          err_clear
);

  localparam logic [11:0] DIV_LAST  = 12'(CLK_DIV - 1);
  localparam logic [3:0]  SAMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  SAMP_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic [11:0]          div_cnt;
  logic                 tick;
  rx_state_t            state, state_d;
  logic [3:0]           samp_cnt, samp_d;
  logic [2:0]           bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 push;
  logic                 frame_set;
  logic                 drop;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      div_cnt   <= '0;
      state     <= ST_IDLE;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      div_cnt   <= tick ? '0 : div_cnt + 12'd1;
      state     <= state_d;
      samp_cnt  <= samp_d;
      bit_cnt   <= bit_d;
      shreg     <= shreg_d;
      // A set in the same cycle as err_clear wins.
      frame_err <= frame_set | (frame_err & ~err_clear);
      overflow  <= drop | (overflow & ~err_clear);
    end
  end

  always_comb begin
    state_d   = state;
    samp_d    = samp_cnt;
    bit_d     = bit_cnt;
    shreg_d   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            samp_d  = '0;
          end
        end
        ST_START: begin
          if (samp_cnt == SAMP_MID) begin
            samp_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            samp_d = samp_cnt + 4'd1;
          end
        end
        ST_DATA: begin
          samp_d = samp_cnt + 4'd1;
          if (samp_cnt == SAMP_LAST) begin
            shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
            bit_d   = bit_cnt + 3'd1;
            if (bit_cnt == BIT_LAST) state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          samp_d = samp_cnt + 4'd1;
          if (samp_cnt == SAMP_LAST) begin
            if (rx_s) begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (shreg),
    .pop     (ready),
    .rdata   (data),
    .valid   (valid),
    .count   (count),
    .drop    (drop)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - scoreboard bench for uart_rx_buffered at CLK_DIV=2 (32 clk per bit)
module tb_uart_rx_buffered;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [4:0] count;
  logic       frame_err;
  logic       overflow;
  logic       err_clear;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         vcyc    = 0;
  logic [7:0] last_pop = '0;
  logic [7:0] exp_q [$];

  uart_rx_buffered #(.CLK_DIV(2), .FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow),
    .err_clear (err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; with catch_push, ready is raised for exactly the cycle the stop bit is accepted.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit catch_push);
    bit caught;
    caught = 1'b0;
    rx = 1'b0;
    tick_clk(32);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick_clk(32);
    end
    rx = stop_bit;
    for (int i = 0; i < 32; i++) begin
      if (catch_push && !caught && dut.push) begin
        ready  = 1'b1;
        caught = 1'b1;
      end else if (catch_push) begin
        ready = 1'b0;
      end
      tick_clk(1);
    end
    if (catch_push) check("catch_push", 32'(caught), 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (valid) vcyc++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", 32'(exp_q.size()), 32'd1);
        end else begin
          check("sb_data", 32'(data), 32'(exp_q.pop_front()));
        end
        last_pop = data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    rx        = 1'b1;
    ready     = 1'b0;
    err_clear = 1'b0;
    tick_clk(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick_clk(10);

    // single byte, consumer always ready
    ready = 1'b1;
    vcyc  = 0;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0);
    tick_clk(8);
    check("a5_valid_cycles", 32'(vcyc), 32'd1);
    check("a5_count", 32'(count), 32'd0);
    check("a5_drained", 32'(exp_q.size()), 32'd0);
    check("a5_ferr", 32'(frame_err), 32'd0);
    check("a5_ovf", 32'(overflow), 32'd0);

    // overflow: 17 bytes into 16 entries, the last is dropped
    ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1'b0);
    end
    tick_clk(4);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    ready = 1'b1;
    tick_clk(24);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_count_empty", 32'(count), 32'd0);
    check("ovf_last", 32'(last_pop), 32'h0F);
    check("ovf_sticky", 32'(overflow), 32'd1);
    err_clear = 1'b1;
    tick_clk(1);
    err_clear = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // short low glitch is rejected at mid start bit
    rx = 1'b0;
    tick_clk(6);
    rx = 1'b1;
    tick_clk(600);
    check("glitch_count", 32'(count), 32'd0);
    check("glitch_idle", 32'(dut.state), 32'(ST_IDLE));
    check("glitch_ferr", 32'(frame_err), 32'd0);
    check("glitch_ovf", 32'(overflow), 32'd0);

    // framing error then long break, then recovery
    send_byte(8'h3C, 1'b0, 1'b0);
    check("fe_flag", 32'(frame_err), 32'd1);
    check("fe_count", 32'(count), 32'd0);
    rx = 1'b0;
    tick_clk(400);
    check("brk_count", 32'(count), 32'd0);
    check("brk_state", 32'(dut.state), 32'(ST_BREAK));
    rx = 1'b1;
    tick_clk(40);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b0);
    tick_clk(8);
    check("fe_recover_drained", 32'(exp_q.size()), 32'd0);
    check("fe_recover_last", 32'(last_pop), 32'h55);
    check("fe_sticky", 32'(frame_err), 32'd1);
    err_clear = 1'b1;
    tick_clk(1);
    err_clear = 1'b0;
    check("fe_cleared", 32'(frame_err), 32'd0);

    // full FIFO with simultaneous push and pop
    ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send_byte(8'h20 + 8'(i), 1'b1, 1'b0);
    end
    check("full_count", 32'(count), 32'd16);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, 1'b1);
    ready = 1'b0;
    tick_clk(2);
    check("full_pp_count", 32'(count), 32'd16);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    ready = 1'b1;
    tick_clk(24);
    check("full_pp_drained", 32'(exp_q.size()), 32'd0);
    check("full_pp_last", 32'(last_pop), 32'h7E);

    // reset in the middle of a frame with a byte buffered
    ready = 1'b0;
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1, 1'b0);
    check("pre_rst_count", 32'(count), 32'd1);
    rx = 1'b0;
    tick_clk(32);
    rx = 1'b1;
    tick_clk(32);
    rx = 1'b0;
    tick_clk(40);
    reset_n = 1'b0;
    rx      = 1'b1;
    tick_clk(1);
    reset_n = 1'b1;
    exp_q.delete();
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    tick_clk(40);
    ready = 1'b1;
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, 1'b0);
    tick_clk(8);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check("post_rst_last", 32'(last_pop), 32'h81);
    check("post_rst_ferr", 32'(frame_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
